// File: rtl/axi_csr_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_csr_responder
// Description : Single-beat AXI4 responder mapping CSR transactions onto a
//               bank of 32-bit registers. One outstanding transaction, writes
//               win over reads, 256-bit data steered to 32-bit lanes,
//               SLVERR on illegal accesses. Reg 0 = BLOCK_ID, reg 1 = status.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_csr_responder #(
  parameter int          NUM_REGS   = 16,
  parameter int          ADDR_WIDTH = 28,
  parameter logic [31:0] BLOCK_ID   = 32'hC5A0_0001
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  // write address
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDR_WIDTH-1:0]    i_awaddr,
  input  logic [7:0]               i_awid,
  input  logic [7:0]               i_awlen,
  // write data
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [255:0]             i_wdata,
  input  logic [31:0]              i_wstrb,
  input  logic                     i_wlast,
  // write response
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [7:0]               o_bid,
  output logic [1:0]               o_bresp,
  // read address
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDR_WIDTH-1:0]    i_araddr,
  input  logic [7:0]               i_arid,
  input  logic [7:0]               i_arlen,
  // read data
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [255:0]             o_rdata,
  output logic [7:0]               o_rid,
  output logic [1:0]               o_rresp,
  output logic                     o_rlast,
  // user side
  input  logic [31:0]              i_status,
  output logic [NUM_REGS*32-1:0]   o_regs,
  output logic [NUM_REGS-1:0]      o_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_BRESP = 2'd2;
  localparam logic [1:0] S_RRESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]            state_q, state_d;
  logic                  ready_en_q;

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awid_q, awlen_q;
  logic [255:0]          wdata_q;
  logic [31:0]           wstrb_q;

  logic [1:0]            bresp_q, rresp_q;
  logic [7:0]            bid_q, rid_q;
  logic [255:0]          rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_commit;

  // Current value of every register as seen by reads and o_regs
  logic [31:0]           w_view [NUM_REGS];

  // Write decode
  logic [7:0]            w_lane_any;
  logic [2:0]            w_lane;
  logic                  w_zero, w_multi, w_ro;
  logic [IDX_W-1:0]      w_widx;
  logic                  w_wr_err, w_wr_ok;
  logic [3:0]            w_bstrb;
  logic [31:0]           w_lane_data, w_wr_old, w_wr_new;

  // Read decode
  logic [IDX_W-1:0]      w_ridx;
  logic                  w_rd_err;
  logic [255:0]          w_rd_data;

  assign w_aw_hs  = i_awvalid & o_awready;
  assign w_w_hs   = i_wvalid  & o_wready;
  assign w_ar_hs  = i_arvalid & o_arready;
  assign w_b_hs   = o_bvalid  & i_bready;
  assign w_r_hs   = o_rvalid  & i_rready;
  assign w_commit = (state_q == S_WRITE) & aw_held_q & w_held_q;

  // Readies stay low for one cycle after reset release
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ready_en_q <= 1'b0;
    else         ready_en_q <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; any write activity in IDLE pre-empts a read
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_aw_hs || w_w_hs) state_d = S_WRITE;
        else if (w_ar_hs)      state_d = S_RRESP;
      end
      S_WRITE: if (aw_held_q && w_held_q) state_d = S_BRESP;
      S_BRESP: if (i_bready)              state_d = S_IDLE;
      S_RRESP: if (i_rready)              state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake readies and response valids
  always_comb begin
    o_awready = ready_en_q & ((state_q == S_IDLE) | (state_q == S_WRITE)) & ~aw_held_q;
    o_wready  = ready_en_q & ((state_q == S_IDLE) | (state_q == S_WRITE)) & ~w_held_q;
    o_arready = ready_en_q & (state_q == S_IDLE) & ~aw_held_q & ~w_held_q
                & ~i_awvalid & ~i_wvalid;
    o_bvalid  = (state_q == S_BRESP);
    o_rvalid  = (state_q == S_RRESP);
  end

  // AW and W hold registers, filled independently, released on B handshake
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      awid_q    <= '0;
      awlen_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (w_b_hs) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (w_aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= i_awaddr;
        awid_q    <= i_awid;
        awlen_q   <= i_awlen;
      end
      if (w_w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= i_wdata;
        wstrb_q  <= i_wstrb;
      end
    end
  end

  // Write decode: strobes pick exactly one 32-bit lane, which supplies the low
  // three index bits; awaddr bits above the lane field supply the rest.
  always_comb begin
    w_lane_any = '0;
    w_lane     = 3'd0;
    for (int l = 0; l < 8; l++) begin
      w_lane_any[l] = |wstrb_q[4*l +: 4];
      if (w_lane_any[l]) w_lane = 3'(l);
    end
    w_zero  = (w_lane_any == 8'd0);
    w_multi = ((w_lane_any & (w_lane_any - 8'd1)) != 8'd0);

    w_widx      = awaddr_q[IDX_W+1:2];
    w_widx[2:0] = w_lane;
    w_ro        = (w_widx[IDX_W-1:1] == '0);

    w_wr_err = (awlen_q != 8'd0)
             | (|awaddr_q[ADDR_WIDTH-1:IDX_W+2])
             | w_multi
             | (~w_zero & w_ro);
    w_wr_ok  = ~w_wr_err & ~w_zero;

    w_bstrb     = wstrb_q[{w_lane, 2'b00} +: 4];
    w_lane_data = wdata_q[{w_lane, 5'b00000} +: 32];
    w_wr_old    = w_view[w_widx];
    for (int b = 0; b < 4; b++) begin
      w_wr_new[8*b +: 8] = w_bstrb[b] ? w_lane_data[8*b +: 8] : w_wr_old[8*b +: 8];
    end
  end

  // Read decode: register value placed in the lane named by araddr[4:2]
  always_comb begin
    w_ridx    = i_araddr[IDX_W+1:2];
    w_rd_err  = (i_arlen != 8'd0) | (|i_araddr[ADDR_WIDTH-1:IDX_W+2]);
    w_rd_data = w_rd_err ? 256'd0
                         : ({224'd0, w_view[w_ridx]} << {i_araddr[4:2], 5'b00000});
  end

  // Register bank: two read-only entries, the rest byte-writable
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    if (n == 0) begin : g_id
      assign w_view[n] = BLOCK_ID;
    end else if (n == 1) begin : g_status
      assign w_view[n] = i_status;
    end else begin : g_rw
      logic [31:0] reg_q;
      // Load merged bytes when a legal write targets this register
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                                        reg_q <= '0;
        else if (w_commit && w_wr_ok && w_widx == IDX_W'(n)) reg_q <= w_wr_new;
      end
      assign w_view[n] = reg_q;
    end
    assign o_regs[32*n +: 32] = w_view[n];
  end

  // One-cycle strobe for the register updated by a committed write
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (w_commit && w_wr_ok) wr_pulse_q[w_widx] <= 1'b1;
    end
  end

  // Response payloads, captured at commit (B) or AR handshake (R)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bresp_q <= RESP_OKAY;
      bid_q   <= '0;
      rresp_q <= RESP_OKAY;
      rid_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (w_commit) begin
        bresp_q <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
        bid_q   <= awid_q;
      end
      if (w_ar_hs) begin
        rresp_q <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        rid_q   <= i_arid;
        rdata_q <= w_rd_data;
      end
    end
  end

  assign o_bresp    = bresp_q;
  assign o_bid      = bid_q;
  assign o_rresp    = rresp_q;
  assign o_rid      = rid_q;
  assign o_rdata    = rdata_q;
  assign o_rlast    = 1'b1;
  assign o_wr_pulse = wr_pulse_q;

  // Inputs and address bits that carry no meaning for this block
  logic w_unused_ok;
  assign w_unused_ok = ^{i_wlast, i_araddr[1:0], awaddr_q[4:0]};

endmodule
`default_nettype wire
